// File: rtl/ask4_sym_upsampler.sv
// ask4_sym_upsampler
//   Front end for the time-shared pulse-shaping filter. Accepts 2-bit Gray-coded
//   4-ASK symbols over a valid/ready handshake and buffers them in a small FIFO.
//   It emits one signed 1s17 sample per sam_clk_en. The first sample of every
//   UPS-sample frame carries the mapped symbol; the other samples are zeros.
//
// Ports
//   sys_clk        in   system clock (only clock)
//   reset          in   synchronous, active-high; discards everything buffered
//   sam_clk_en     in   one-cycle sample strobe
//   sym_data       in   Gray-coded symbol bits
//   sym_valid      in   sym_data is valid
//   sym_ready      out  FIFO has room this cycle (decoded from registered level only)
//   clr_underflow  in   clears the sticky underflow flag
//   x_out          out  registered upsampled sample to the filter
//   sym_clk_en     out  one-cycle pulse: x_out was just loaded at a symbol slot
//   fifo_level     out  number of buffered symbols
//   underflow      out  sticky: a symbol slot found the FIFO empty
module ask4_sym_upsampler #(
   parameter int WIDTH      = 18,
   parameter int UPS        = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int LVL_A      = 32768
) (
   input  logic                          sys_clk,
   input  logic                          reset,
   input  logic                          sam_clk_en,
   input  logic [1:0]                    sym_data,
   input  logic                          sym_valid,
   output logic                          sym_ready,
   input  logic                          clr_underflow,
   output logic signed [WIDTH-1:0]       x_out,
   output logic                          sym_clk_en,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          underflow
);

   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int LW  = PW + 1;
   localparam int PHW = $clog2(UPS);

   // Level constants are fixed at elaboration, so the datapath never multiplies.
   localparam logic signed [WIDTH-1:0] LVL_P1 = WIDTH'(LVL_A);
   localparam logic signed [WIDTH-1:0] LVL_P3 = WIDTH'(3 * LVL_A);
   localparam logic signed [WIDTH-1:0] LVL_M1 = WIDTH'(-LVL_A);
   localparam logic signed [WIDTH-1:0] LVL_M3 = WIDTH'(-3 * LVL_A);

   // The outer level 3a must fit in 1s17. The pointers rely on wrap-around of a power-of-two depth.
   if (LVL_A > 43690 || LVL_A < 0) begin : g_lvl_chk
      $error("ask4_sym_upsampler: LVL_A must be in 0..43690");
   end
   if (UPS < 2) begin : g_ups_chk
      $error("ask4_sym_upsampler: UPS must be >= 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
      $error("ask4_sym_upsampler: FIFO_DEPTH must be a power of 2, >= 2");
   end

   // Gray map: 00 -> -3a, 01 -> -a, 11 -> +a, 10 -> +3a
   function automatic logic signed [WIDTH-1:0] gray_map(input logic [1:0] sym);
      logic signed [WIDTH-1:0] lvl;
      case (sym)
         2'b00:   lvl = LVL_M3;
         2'b01:   lvl = LVL_M1;
         2'b11:   lvl = LVL_P1;
         2'b10:   lvl = LVL_P3;
         default: lvl = LVL_P3;
      endcase
      return lvl;
   endfunction

   logic [1:0]              mem_q [FIFO_DEPTH];
   logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]           level_q, level_d;
   logic [PHW-1:0]          ph_q, ph_d;
   logic signed [WIDTH-1:0] x_q, x_d;
   logic                    sce_q, sce_d;
   logic                    uf_q, uf_d;

   logic full_s, empty_s, push_s, slot_s, pop_s;

   // Handshake, slot detection and next-state for all control/datapath registers
   always_comb begin
      full_s   = (level_q == LW'(FIFO_DEPTH));
      empty_s  = (level_q == {LW{1'b0}});
      push_s   = sym_valid && !full_s;
      slot_s   = sam_clk_en && (ph_q == {PHW{1'b0}});
      // The pop decision uses the pre-edge level, so a same-cycle push into an empty FIFO is not popped.
      pop_s    = slot_s && !empty_s;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      ph_d     = ph_q;
      x_d      = x_q;
      sce_d    = slot_s;
      uf_d     = uf_q;

      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      if (sam_clk_en) begin
         if (ph_q == PHW'(UPS - 1)) begin
            ph_d = {PHW{1'b0}};
         end else begin
            ph_d = ph_q + PHW'(1);
         end
         // Every strobe reloads x: a symbol at a populated slot, a zero otherwise
         if (pop_s) begin
            x_d = gray_map(mem_q[rd_ptr_q]);
         end else begin
            x_d = {WIDTH{1'b0}};
         end
      end else begin
         ph_d = ph_q;
         x_d  = x_q;
      end

      // Setting the flag takes priority over clearing it
      if (slot_s && empty_s) begin
         uf_d = 1'b1;
      end else if (clr_underflow) begin
         uf_d = 1'b0;
      end else begin
         uf_d = uf_q;
      end
   end

   // Symbol storage; contents need no reset because the pointers define validity
   always_ff @(posedge sys_clk) begin
      if (push_s && !reset) begin
         mem_q[wr_ptr_q] <= sym_data;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         level_q  <= {LW{1'b0}};
         ph_q     <= {PHW{1'b0}};
         x_q      <= {WIDTH{1'b0}};
         sce_q    <= 1'b0;
         uf_q     <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ph_q     <= ph_d;
         x_q      <= x_d;
         sce_q    <= sce_d;
         uf_q     <= uf_d;
      end
   end

   assign sym_ready  = !full_s;
   assign x_out      = x_q;
   assign sym_clk_en = sce_q;
   assign fifo_level = level_q;
   assign underflow  = uf_q;

endmodule

// File: tb/tb_ask4_sym_upsampler.sv
// Self-checking bench for ask4_sym_upsampler (default parameters).
module tb_ask4_sym_upsampler;

   logic               sys_clk = 1'b0;
   logic               reset;
   logic               sam_clk_en;
   logic [1:0]         sym_data;
   logic               sym_valid;
   logic               sym_ready;
   logic               clr_underflow;
   logic signed [17:0] x_out;
   logic               sym_clk_en;
   logic [3:0]         fifo_level;
   logic               underflow;

   int errors = 0;
   int checks = 0;

   ask4_sym_upsampler dut (
      .sys_clk       (sys_clk),
      .reset         (reset),
      .sam_clk_en    (sam_clk_en),
      .sym_data      (sym_data),
      .sym_valid     (sym_valid),
      .sym_ready     (sym_ready),
      .clr_underflow (clr_underflow),
      .x_out         (x_out),
      .sym_clk_en    (sym_clk_en),
      .fifo_level    (fifo_level),
      .underflow     (underflow)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic       v;
      logic [1:0] d;
      logic       s;
      logic       c;
      int         ex;
      int         esce;
      int         elvl;
      int         erdy;
      int         euf;
   } vec_t;

   vec_t tbl [36];

   function automatic vec_t mk(input logic v, input logic [1:0] d, input logic s, input logic c,
                               input int ex, input int esce, input int elvl, input int erdy,
                               input int euf);
      vec_t r;
      r.v = v; r.d = d; r.s = s; r.c = c;
      r.ex = ex; r.esce = esce; r.elvl = elvl; r.erdy = erdy; r.euf = euf;
      return r;
   endfunction

   function automatic int lvl(input logic [1:0] d);
      case (d)
         2'b00:   return -98304;
         2'b01:   return -32768;
         2'b11:   return 32768;
         default: return 98304;
      endcase
   endfunction

   task automatic chk(input string nm, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, expv);
      end
   endtask

   // one sys_clk: inputs already set; sample 1 time unit after the edge
   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] d, input logic s, input logic c);
      sym_valid = v; sym_data = d; sam_clk_en = s; clr_underflow = c;
   endtask

   task automatic chk_all(input string nm, input int ex, input int esce, input int elvl,
                          input int erdy, input int euf);
      chk({nm, ".x"},     int'(x_out),      ex);
      chk({nm, ".sce"},   int'(sym_clk_en), esce);
      chk({nm, ".level"}, int'(fifo_level), elvl);
      chk({nm, ".ready"}, int'(sym_ready),  erdy);
      chk({nm, ".uf"},    int'(underflow),  euf);
   endtask

   task automatic do_reset();
      drive(1'b0, 2'b00, 1'b0, 1'b0);
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   logic [1:0] q [$];
   int         mph, mx, msce, muf;

   initial begin
      reset = 1'b1;
      drive(1'b0, 2'b00, 1'b0, 1'b0);

      // Directed table: push four symbols, then frames of strobes, underflow and clear cases
      tbl[0]  = mk(1'b1, 2'b00, 1'b0, 1'b0,      0, 0, 1, 1, 0);
      tbl[1]  = mk(1'b1, 2'b01, 1'b0, 1'b0,      0, 0, 2, 1, 0);
      tbl[2]  = mk(1'b1, 2'b11, 1'b0, 1'b0,      0, 0, 3, 1, 0);
      tbl[3]  = mk(1'b1, 2'b10, 1'b0, 1'b0,      0, 0, 4, 1, 0);
      tbl[4]  = mk(1'b0, 2'b00, 1'b1, 1'b0, -98304, 1, 3, 1, 0);
      tbl[5]  = mk(1'b0, 2'b00, 1'b0, 1'b0, -98304, 0, 3, 1, 0);
      for (int i = 6; i <= 8; i++) tbl[i] = mk(1'b0, 2'b00, 1'b1, 1'b0, 0, 0, 3, 1, 0);
      tbl[9]  = mk(1'b0, 2'b00, 1'b1, 1'b0, -32768, 1, 2, 1, 0);
      for (int i = 10; i <= 12; i++) tbl[i] = mk(1'b0, 2'b00, 1'b1, 1'b0, 0, 0, 2, 1, 0);
      tbl[13] = mk(1'b0, 2'b00, 1'b1, 1'b0,  32768, 1, 1, 1, 0);
      tbl[14] = mk(1'b0, 2'b00, 1'b0, 1'b0,  32768, 0, 1, 1, 0);
      for (int i = 15; i <= 17; i++) tbl[i] = mk(1'b0, 2'b00, 1'b1, 1'b0, 0, 0, 1, 1, 0);
      tbl[18] = mk(1'b0, 2'b00, 1'b1, 1'b0,  98304, 1, 0, 1, 0);
      for (int i = 19; i <= 21; i++) tbl[i] = mk(1'b0, 2'b00, 1'b1, 1'b0, 0, 0, 0, 1, 0);
      tbl[22] = mk(1'b0, 2'b00, 1'b1, 1'b0,      0, 1, 0, 1, 1);
      tbl[23] = mk(1'b0, 2'b00, 1'b0, 1'b1,      0, 0, 0, 1, 0);
      tbl[24] = mk(1'b1, 2'b01, 1'b1, 1'b0,      0, 0, 1, 1, 0);
      tbl[25] = mk(1'b0, 2'b00, 1'b1, 1'b0,      0, 0, 1, 1, 0);
      tbl[26] = mk(1'b0, 2'b00, 1'b1, 1'b0,      0, 0, 1, 1, 0);
      tbl[27] = mk(1'b0, 2'b00, 1'b1, 1'b1, -32768, 1, 0, 1, 0);
      for (int i = 28; i <= 30; i++) tbl[i] = mk(1'b0, 2'b00, 1'b1, 1'b0, 0, 0, 0, 1, 0);
      // push at an empty slot with clear asserted: underflow set wins, symbol waits a full frame
      tbl[31] = mk(1'b1, 2'b10, 1'b1, 1'b1,      0, 1, 1, 1, 1);
      for (int i = 32; i <= 34; i++) tbl[i] = mk(1'b0, 2'b00, 1'b1, 1'b0, 0, 0, 1, 1, 1);
      tbl[35] = mk(1'b0, 2'b00, 1'b1, 1'b0,  98304, 1, 0, 1, 1);

      do_reset();
      chk_all("reset", 0, 0, 0, 1, 0);

      for (int i = 0; i < 36; i++) begin
         drive(tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].c);
         step();
         chk_all($sformatf("tbl[%0d]", i), tbl[i].ex, tbl[i].esce, tbl[i].elvl,
                 tbl[i].erdy, tbl[i].euf);
      end

      // Full FIFO: hold valid with no strobes; only 8 symbols are taken
      do_reset();
      for (int k = 0; k < 12; k++) begin
         drive(1'b1, (k < 8) ? 2'(k) : 2'b10, 1'b0, 1'b0);
         step();
      end
      chk("full.level", int'(fifo_level), 8);
      chk("full.ready", int'(sym_ready), 0);
      // strobe while full with valid high: pop only, no push
      drive(1'b1, 2'b11, 1'b1, 1'b0);
      step();
      chk_all("full.pop", lvl(2'b00), 1, 7, 1, 0);
      drive(1'b0, 2'b00, 1'b0, 1'b0);
      for (int j = 1; j < 8; j++) begin
         drive(1'b0, 2'b00, 1'b1, 1'b0);
         for (int p = 0; p < 3; p++) step();
         chk($sformatf("drain[%0d].zero", j), int'(x_out), 0);
         step();
         chk($sformatf("drain[%0d].x", j), int'(x_out), lvl(2'(j)));
         chk($sformatf("drain[%0d].level", j), int'(fifo_level), 7 - j);
      end
      drive(1'b0, 2'b00, 1'b0, 1'b0);
      step();
      chk("drain.sce_low", int'(sym_clk_en), 0);

      // Reset in mid-operation discards buffered symbols and the phase
      do_reset();
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, 2'(k), 1'b0, 1'b0);
         step();
      end
      chk("mid.level5", int'(fifo_level), 5);
      drive(1'b0, 2'b00, 1'b1, 1'b0);
      step();
      chk("mid.pop", int'(x_out), lvl(2'b00));
      drive(1'b0, 2'b00, 1'b0, 1'b0);
      step();
      drive(1'b1, 2'b11, 1'b1, 1'b0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      drive(1'b0, 2'b00, 1'b0, 1'b0);
      chk_all("mid.rst", 0, 0, 0, 1, 0);
      step();
      drive(1'b0, 2'b00, 1'b1, 1'b0);
      step();
      chk_all("mid.slot", 0, 1, 0, 1, 1);

      // Random traffic against a queue model
      do_reset();
      q.delete();
      mph = 0; mx = 0; msce = 0; muf = 0;
      begin
         int gap;
         gap = 1;
         for (int n = 0; n < 6000; n++) begin
            logic v, s, c, m_slot, m_pop, m_push;
            logic [1:0] d;
            v = (n < 3000) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
            d = 2'($urandom_range(0, 3));
            gap--;
            s = (gap == 0);
            if (s) gap = $urandom_range(1, 5);
            c = ($urandom_range(0, 15) == 0);
            drive(v, d, s, c);

            m_push = v && (q.size() != 8);
            m_slot = s && (mph == 0);
            m_pop  = m_slot && (q.size() != 0);
            if (s) mx = m_pop ? lvl(q[0]) : 0;
            msce = m_slot ? 1 : 0;
            if (m_slot && q.size() == 0) muf = 1;
            else if (c) muf = 0;
            if (m_pop) void'(q.pop_front());
            if (m_push) q.push_back(d);
            if (s) mph = (mph == 3) ? 0 : mph + 1;

            step();
            chk_all($sformatf("rnd[%0d]", n), mx, msce, q.size(), (q.size() != 8) ? 1 : 0, muf);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
